// File: rtl/main_memory_if.sv
// Cache-to-main-memory request/response bundle.
// master = cache side, slave = main_memory side.
interface main_memory_if;
    logic         ic_rqst_i;
    logic [19:0]  ic_addr_i;
    logic         dc_rqst_i;
    logic         dc_write_i;
    logic [19:0]  dc_addr_i;
    logic [127:0] dc_data_i;
    logic         ic_data_ready_o;
    logic         dc_data_ready_o;
    logic [127:0] mem_data_o;
    logic [19:0]  mem_addr_o;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
    logic         mem_error_o;
`endif

    modport master (
        output ic_rqst_i, ic_addr_i,
        output dc_rqst_i, dc_write_i, dc_addr_i, dc_data_i,
        input  ic_data_ready_o, dc_data_ready_o,
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
        input  mem_error_o,
`endif
        input  mem_data_o, mem_addr_o
    );

    modport slave (
        input  ic_rqst_i, ic_addr_i,
        input  dc_rqst_i, dc_write_i, dc_addr_i, dc_data_i,
        output ic_data_ready_o, dc_data_ready_o,
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
        output mem_error_o,
`endif
        output mem_data_o, mem_addr_o
    );
endinterface

// File: rtl/main_memory.sv
// Main-memory responder for icache/dcache line fills and writebacks.
// Ports: clk_i, rsn_i (async active-low), bus (main_memory_if.slave).
// Optional MAIN_MEMORY_RANGE_CHECK_EN adds out-of-range detection.
module main_memory #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 1024
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    main_memory_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            last_dc_q;
    logic            sel_dc_q;
    logic            wr_q;
    logic [19:4]     addr_q;
    logic [127:0]    wdata_q;
    logic [127:0]    mem_q [DEPTH];
    logic            ic_rdy_q, dc_rdy_q;
    logic [127:0]    data_q;
    logic [19:0]     maddr_q;

    logic            any_rqst, pick_dc, capture, go_resp, range_err;
    logic [IW-1:0]   idx;

    assign any_rqst = bus.ic_rqst_i | bus.dc_rqst_i;
    // Alternate on contention; a lone requester always wins.
    assign pick_dc  = bus.dc_rqst_i & (~bus.ic_rqst_i | ~last_dc_q);
    assign capture  = (state_q == IDLE) & any_rqst;
    assign go_resp  = (state_q == BUSY) & (cnt_q == '0);
    assign idx      = addr_q[IW+3:4];

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
    assign range_err = |addr_q[19:IW+4];
`else
    assign range_err = 1'b0;
    logic unused_hi;
    assign unused_hi = ^addr_q[19:IW+4];
`endif

    logic unused_lsb;
    assign unused_lsb = ^{bus.ic_addr_i[3:0], bus.dc_addr_i[3:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_rqst) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_dc_q <= 1'b0;
            sel_dc_q  <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cnt_q     <= CW'(LATENCY - 2);
                last_dc_q <= pick_dc;
                sel_dc_q  <= pick_dc;
                wr_q      <= pick_dc & bus.dc_write_i;
                addr_q    <= pick_dc ? bus.dc_addr_i[19:4]
                                     : bus.ic_addr_i[19:4];
                wdata_q   <= bus.dc_data_i;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // The access happens on the edge entering RESP so that data and
    // the ready pulse are both registered outputs during RESP.
    always_ff @(posedge clk_i) begin
        if (go_resp && wr_q && !range_err)
            mem_q[idx] <= wdata_q;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ic_rdy_q <= 1'b0;
            dc_rdy_q <= 1'b0;
            data_q   <= '0;
            maddr_q  <= '0;
        end else begin
            ic_rdy_q <= go_resp & ~sel_dc_q;
            dc_rdy_q <= go_resp & sel_dc_q;
            if (go_resp) begin
                maddr_q <= {addr_q, 4'h0};
                if (range_err)
                    data_q <= '0;
                else if (wr_q)
                    data_q <= wdata_q;
                else
                    data_q <= mem_q[idx];
            end
        end
    end

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) err_q <= 1'b0;
        else        err_q <= go_resp & range_err;
    end
    assign bus.mem_error_o = err_q;
`endif

    assign bus.ic_data_ready_o = ic_rdy_q;
    assign bus.dc_data_ready_o = dc_rdy_q;
    assign bus.mem_data_o      = data_q;
    assign bus.mem_addr_o      = maddr_q;
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: driver issues cache requests,
// a reference model predicts responses, a monitor checks them.
`timescale 1ns/1ps
module tb_main_memory;
    localparam int L     = 5;
    localparam int DEPTH = 1024;
    localparam int IW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    main_memory_if bus();

    main_memory #(.LATENCY(L), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_dc;
        logic [19:0]  addr;
        logic [127:0] data;
        bit           known;
        bit           err;
        int           edge_n;
    } exp_t;

    exp_t sbq[$];
    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] mem_m [int];
    bit last_dc   = 1'b0;
    int free_edge = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: one request served per capture edge.
    function automatic int serve(bit is_dc, bit wr, logic [19:0] a,
                                 logic [127:0] d, int cap);
        exp_t e;
        int idx;
        bit err;
        idx = int'(a[IW+3:4]);
        err = 1'b0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
        err = (a[19:IW+4] != 0);
`endif
        e.is_dc  = is_dc;
        e.addr   = {a[19:4], 4'h0};
        e.edge_n = cap + L - 1;
        e.err    = err;
        if (err) begin
            e.data = '0; e.known = 1'b1;
        end else if (wr) begin
            mem_m[idx] = d; e.data = d; e.known = 1'b1;
        end else if (mem_m.exists(idx)) begin
            e.data = mem_m[idx]; e.known = 1'b1;
        end else begin
            e.data = '0; e.known = 1'b0;
        end
        sbq.push_back(e);
        free_edge = e.edge_n + 2;
        last_dc   = is_dc;
        return e.edge_n;
    endfunction

    always @(negedge clk) begin
        if (rsn && (bus.ic_data_ready_o || bus.dc_data_ready_o)) begin
            exp_t e;
            chk("single_ready",
                128'(bus.ic_data_ready_o & bus.dc_data_ready_o), 128'(0));
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ready: got ready with no pending request (cyc %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("ready_side", 128'(bus.dc_data_ready_o), 128'(e.is_dc));
                chk("ready_cycle", 128'(cyc), 128'(e.edge_n));
                chk("mem_addr", 128'(bus.mem_addr_o), 128'(e.addr));
                if (e.known) chk("mem_data", bus.mem_data_o, e.data);
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
                chk("mem_error", 128'(bus.mem_error_o), 128'(e.err));
`endif
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_ic_ready", 128'(bus.ic_data_ready_o), 128'(0));
        chk("rst_dc_ready", 128'(bus.dc_data_ready_o), 128'(0));
        chk("rst_mem_data", bus.mem_data_o, 128'(0));
        chk("rst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
        chk("rst_mem_error", 128'(bus.mem_error_o), 128'(0));
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rsn = 1'b0;
        bus.ic_rqst_i = 1'b0;
        bus.dc_rqst_i = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        rsn = 1'b1;
        free_edge = 0;
        last_dc   = 1'b0;
    endtask

    task automatic round(bit do_ic, logic [19:0] ia, bit do_dc, bit dw,
                         logic [19:0] da, logic [127:0] dd, bit hold);
        int r, cap, t, ic_need, dc_need, drop_cnt;
        bit ic_first;
        while (cyc + 1 < free_edge) @(negedge clk);
        cap = cyc + 1;
        ic_first = do_ic && (!do_dc || last_dc);
        if (do_ic && do_dc) begin
            if (ic_first) begin
                r = serve(1'b0, 1'b0, ia, '0, cap);
                r = serve(1'b1, dw, da, dd, r + 2);
            end else begin
                r = serve(1'b1, dw, da, dd, cap);
                r = serve(1'b0, 1'b0, ia, '0, r + 2);
            end
        end else if (do_ic) begin
            r = serve(1'b0, 1'b0, ia, '0, cap);
            if (hold) r = serve(1'b0, 1'b0, ia, '0, r + 2);
        end else begin
            r = serve(1'b1, dw, da, dd, cap);
        end
        bus.ic_rqst_i  = do_ic;
        bus.ic_addr_i  = ia;
        bus.dc_rqst_i  = do_dc;
        bus.dc_write_i = dw;
        bus.dc_addr_i  = da;
        bus.dc_data_i  = dd;
        ic_need  = do_ic ? (hold ? 2 : 1) : 0;
        dc_need  = do_dc ? 1 : 0;
        drop_cnt = -1;
        t = 0;
        while ((ic_need > 0 || dc_need > 0) && t < 60) begin
            @(negedge clk);
            t++;
            // Captured dcache inputs must no longer matter.
            if (t == 1 && do_dc && !ic_first) begin
                bus.dc_addr_i = 20'($urandom);
                bus.dc_data_i = rnd128();
            end
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) bus.ic_rqst_i = 1'b0;
            end
            if (bus.ic_data_ready_o && ic_need > 0) begin
                ic_need--;
                if (hold && drop_cnt < 0) drop_cnt = 2;
                else bus.ic_rqst_i = 1'b0;
            end
            if (bus.dc_data_ready_o && dc_need > 0) begin
                dc_need--;
                bus.dc_rqst_i = 1'b0;
                bus.dc_data_i = rnd128();
            end
        end
        if (ic_need > 0 || dc_need > 0) begin
            n_chk++; n_fail++;
            $display("FAIL round_timeout: ic_need %0d dc_need %0d required 0", ic_need, dc_need);
            bus.ic_rqst_i = 1'b0;
            bus.dc_rqst_i = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ic_rqst_i  = 1'b1;
        bus.ic_addr_i  = 20'h00100;
        bus.dc_rqst_i  = 1'b0;
        bus.dc_write_i = 1'b0;
        bus.dc_addr_i  = '0;
        bus.dc_data_i  = '0;
        rsn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rsn = 1'b1;
        free_edge = 0;
        round(1'b1, 20'h00100, 1'b0, 1'b0, '0, '0, 1'b0);

        for (int i = 0; i < 16; i++)
            round(1'b0, '0, 1'b1, 1'b1, 20'(i << 4), rnd128(), 1'b0);
        round(1'b1, 20'h00100, 1'b0, 1'b0, '0, '0, 1'b0);

        round(1'b0, '0, 1'b1, 1'b1, 20'h00040,
              128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
        round(1'b0, '0, 1'b1, 1'b0, 20'h0004C, '0, 1'b0);

        apply_reset();
        round(1'b1, 20'h00100, 1'b1, 1'b0, 20'h00200, '0, 1'b0);
        round(1'b0, '0, 1'b1, 1'b0, 20'h00030, '0, 1'b0);
        round(1'b1, 20'h00010, 1'b1, 1'b0, 20'h00020, '0, 1'b0);

        round(1'b1, 20'h00050, 1'b0, 1'b0, '0, '0, 1'b1);

        // Writeback interrupted by reset while BUSY must be lost.
        while (cyc + 1 < free_edge) @(negedge clk);
        bus.dc_rqst_i  = 1'b1;
        bus.dc_write_i = 1'b1;
        bus.dc_addr_i  = 20'h00080;
        bus.dc_data_i  = rnd128();
        repeat (3) @(negedge clk);
        rsn = 1'b0;
        bus.dc_rqst_i = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        rsn = 1'b1;
        free_edge = 0;
        last_dc   = 1'b0;
        round(1'b0, '0, 1'b1, 1'b0, 20'h00080, '0, 1'b0);

        round(1'b1, 20'h04010, 1'b0, 1'b0, '0, '0, 1'b0);
        round(1'b0, '0, 1'b1, 1'b1, 20'h0C020, rnd128(), 1'b0);
        round(1'b0, '0, 1'b1, 1'b0, 20'h00020, '0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit di, dd_, dw;
            logic [19:0] ia, da;
            di  = 1'($urandom);
            dd_ = 1'($urandom);
            if (!di && !dd_) dd_ = 1'b1;
            dw  = 1'($urandom);
            ia  = {6'($urandom_range(0, 3) == 0 ? $urandom : 0),
                   4'h0, 6'($urandom_range(0, 15)), 4'($urandom)};
            da  = {6'($urandom_range(0, 3) == 0 ? $urandom : 0),
                   4'h0, 6'($urandom_range(0, 15)), 4'($urandom)};
            round(di, ia, dd_, dw, da, rnd128(), 1'($urandom_range(0, 7) == 0) && !dd_);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/main_memory.md
# main_memory

Main-memory responder serving line fills and line writebacks for the instruction cache and data cache. It is the memory side of the cache `rqst_to_mem_o` / `addr_to_mem_o` / `mem_data_ready_i` / `mem_data_i` / `mem_addr_i` interface. It sits outside `vi_core` and accepts one request at a time from either cache. Each request completes after a fixed, configurable latency, and the block alternates between the caches when both request in the same cycle.

## Interface
- `LATENCY`, 5: cycles from request capture to the ready pulse; must be ≥ 2.
- `DEPTH`, 1024: number of 128-bit lines stored; must be a power of two.
- `clk_i` in 1: core clock.
- `rsn_i` in 1: reset, asynchronous, active-low.
- `ic_rqst_i` in 1: icache read request, held high until `ic_data_ready_o`.
- `ic_addr_i` in 20: icache physical byte address; bits [3:0] are ignored.
- `dc_rqst_i` in 1: dcache request, held high until `dc_data_ready_o`.
- `dc_write_i` in 1: dcache request is a writeback (1) or a fill (0).
- `dc_addr_i` in 20: dcache physical byte address; bits [3:0] are ignored.
- `dc_data_i` in 128: writeback line data, valid with `dc_rqst_i` && `dc_write_i`.
- `ic_data_ready_o` out 1: one-cycle completion pulse for the icache.
- `dc_data_ready_o` out 1: one-cycle completion pulse for the dcache.
- `mem_data_o` out 128: line data, valid while either ready output is high.
- `mem_addr_o` out 20: line-aligned address of the completing request, with [3:0] = 0.
- `mem_error_o` out 1: out-of-range request. Exists only with `MAIN_MEMORY_RANGE_CHECK_EN`.

## Operation
- Storage: `DEPTH` × 128-bit array, not reset. Line index = addr[log2(DEPTH)+3:4].
- FSM states:
  - IDLE: if any request is present, capture requester, address, write flag and write data into registers, load `cnt` = LATENCY-2, go to BUSY.
  - BUSY: if `cnt` == 0, go to RESP; otherwise `cnt` decrements by 1.
  - RESP: perform the access, then go to IDLE. A read returns `mem_data_o` = array[index]. A write updates array[index] with the captured data and `mem_data_o` echoes that data. The ready pulse goes to the captured requester.
  - IDLE is always spent for at least one cycle after RESP. This lets the requester drop its request, so a request still held during RESP is never recaptured.
- Arbitration: a `last_dc` register records whether the dcache was served last; it resets to 0.
  - Only one request present: serve it.
  - Both present: serve the dcache if `last_dc` == 0, otherwise the icache. `last_dc` updates at every capture.
- Inputs are sampled only in IDLE. Changes to a request's address or data after capture are ignored.
- `ic_rqst_i` and `dc_rqst_i` are never both answered in one cycle. Exactly one ready pulse occurs per captured request.
- A request dropped before its ready pulse is a protocol error. The block still completes the captured request.
- Reset mid-operation returns the FSM to IDLE and clears `cnt` and `last_dc`. Array contents are retained. A write not yet in RESP is lost.
- Reset values: `ic_data_ready_o` = 0, `dc_data_ready_o` = 0, `mem_data_o` = 0, `mem_addr_o` = 0, `mem_error_o` = 0.
- `mem_data_o` and `mem_addr_o` hold their last value outside RESP.

## Timing
- Request high at edge k (state IDLE) → captured at edge k. State is BUSY for cycles k+1 … k+LATENCY-1. The ready pulse is high during cycle k+LATENCY.
- Minimum spacing between captures is LATENCY+1 cycles.
- Read data is registered, with no combinational path from inputs to outputs.
- A write followed by a read to the same line returns the new data; this is guaranteed by serialisation.
- With `last_dc` = 0 and both caches requesting at edge k:
  - dcache ready in cycle k+L.
  - icache captured at edge k+L+1.
  - icache ready in cycle k+2L+1.

## Configuration
- `MAIN_MEMORY_RANGE_CHECK_EN` defined:
  - addr[19:log2(DEPTH)+4] ≠ 0 marks the request out-of-range.
  - In RESP, `mem_error_o` pulses with the ready output, `mem_data_o` = 0, and writes are dropped.
- `MAIN_MEMORY_RANGE_CHECK_EN` undefined:
  - There is no `mem_error_o` port.
  - Upper address bits are ignored and the index wraps; for example, 0x04010 with DEPTH = 1024 aliases 0x00010.

## Test plan
- Reset with a request held: hold `ic_rqst_i` with `rsn_i` low → all outputs 0. Release reset at edge 0 → `ic_data_ready_o` high only in cycle 5 (LATENCY = 5).
- Write then read: dcache writeback of 0x00040 with data 0x0123…CDEF, then a dcache fill of 0x0004C → fill returns the same 128-bit value and `mem_addr_o` = 0x00040.
- Simultaneous requests: icache 0x00100 and dcache 0x00200 both at edge 0 after reset → `dc_data_ready_o` in cycle 5, `ic_data_ready_o` in cycle 11. The next simultaneous pair serves the icache first.
- Held request: keep `ic_rqst_i` high for 2 cycles after the ready pulse → a second capture occurs one cycle after RESP. No double pulse appears within a single transaction.
- Reset mid-operation: assert reset in BUSY during a dcache writeback to 0x00080 → no ready pulse, and a later read of 0x00080 returns the old data.
- Range check: with `MAIN_MEMORY_RANGE_CHECK_EN`, read 0x04010 → `mem_error_o` = 1 and data = 0. Without the macro, it returns the line at 0x00010.
